// File: rtl/ntt_coef_loader.sv
// ntt_coef_loader: packs a serial coefficient stream into LANES-wide register-file writes.
// Optional build macro NTT_LOADER_BITREV_EN selects bit-reversed lane addresses (natural order otherwise).
module ntt_coef_loader #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 256,
    parameter int LANES      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          in_valid_i,
    input  logic [WIDTH-1:0]              in_data_i,
    output logic                          in_ready_o,
    output logic                          we_o,
    output logic [LANES*ADDR_WIDTH-1:0]   waddr_o,
    output logic [LANES*WIDTH-1:0]        din_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int GRPS   = DEPTH / LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GRP_W  = (GRPS > 1) ? $clog2(GRPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                        r_state;
    logic [LANE_W-1:0]             r_lane;
    logic [GRP_W-1:0]              r_grp;
    logic [WIDTH-1:0]              r_pack [LANES];
    logic                          r_we;
    logic                          r_done;
    logic [LANES*ADDR_WIDTH-1:0]   r_waddr;
    logic [LANES*WIDTH-1:0]        r_din;

    logic [LANES*WIDTH-1:0]        w_din;
    logic [LANES*ADDR_WIDTH-1:0]   w_waddr;
    logic                          w_accept;
    logic                          w_last_lane;
    logic                          w_last_grp;

    function automatic logic [ADDR_WIDTH-1:0] f_bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    assign in_ready_o  = (r_state == S_FILL);
    assign busy_o      = (r_state == S_FILL) || (r_state == S_WRITE);
    assign done_o      = r_done;
    assign we_o        = r_we;
    assign waddr_o     = r_waddr;
    assign din_o       = r_din;

    assign w_accept    = in_valid_i && in_ready_o;
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
    assign w_last_grp  = (r_grp == GRP_W'(GRPS - 1));

    // The closing beat of a group bypasses the pack buffer so the write issues on the next cycle.
    always_comb begin
        w_din = '0;
        for (int k = 0; k < LANES; k++) begin
            if (LANE_W'(k) == r_lane) begin
                w_din[k*WIDTH +: WIDTH] = in_data_i;
            end else begin
                w_din[k*WIDTH +: WIDTH] = r_pack[k];
            end
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] w_nat;
        w_waddr = '0;
        for (int k = 0; k < LANES; k++) begin
            w_nat = ADDR_WIDTH'(int'(r_grp) * LANES + k);
`ifdef NTT_LOADER_BITREV_EN
            w_waddr[k*ADDR_WIDTH +: ADDR_WIDTH] = f_bitrev(w_nat);
`else
            w_waddr[k*ADDR_WIDTH +: ADDR_WIDTH] = w_nat;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
            r_grp   <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_waddr <= '0;
            r_din   <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_pack[k] <= '0;
            end
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_FILL;
                        r_lane  <= '0;
                        r_grp   <= '0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_pack[r_lane] <= in_data_i;
                        if (w_last_lane) begin
                            r_lane  <= '0;
                            r_state <= S_WRITE;
                            r_we    <= 1'b1;
                            r_din   <= w_din;
                            r_waddr <= w_waddr;
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_grp <= r_grp + GRP_W'(1);
                    if (w_last_grp) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_coef_loader.sv
// tb_ntt_coef_loader: directed/randomized load sequences checked against a per-index reference model.
// Honours NTT_LOADER_BITREV_EN when computing expected lane addresses.
module tb_ntt_coef_loader;

    localparam int WIDTH      = 12;
    localparam int DEPTH      = 256;
    localparam int LANES      = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int GROUPS     = DEPTH / LANES;

    logic                        clk;
    logic                        rst_n;
    logic                        start;
    logic                        inValid;
    logic [WIDTH-1:0]            inData;
    logic                        inReady;
    logic                        we;
    logic [LANES*ADDR_WIDTH-1:0] waddr;
    logic [LANES*WIDTH-1:0]      din;
    logic                        busy;
    logic                        done;

    int vecCount;
    int missCount;
    int cyc;
    int startCyc;
    int doneCyc;
    int doneCnt;
    int readyInWrite;
    int vals [DEPTH];

    logic [LANES*WIDTH-1:0]      wrData [$];
    logic [LANES*ADDR_WIDTH-1:0] wrAddr [$];
    int                          wrCyc  [$];

    ntt_coef_loader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .in_valid_i(inValid), .in_data_i(inData), .in_ready_o(inReady),
        .we_o(we), .waddr_o(waddr), .din_o(din), .busy_o(busy), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records every write and done pulse seen on the outputs.
    always @(negedge clk) begin
        if (we) begin
            wrData.push_back(din);
            wrAddr.push_back(waddr);
            wrCyc.push_back(cyc);
            if (inReady) readyInWrite++;
        end
        if (done) doneCnt++;
    end

    function automatic logic [ADDR_WIDTH-1:0] mapAddr(input int idx);
        logic [ADDR_WIDTH-1:0] n;
        logic [ADDR_WIDTH-1:0] r;
        n = ADDR_WIDTH'(idx);
        r = n;
`ifdef NTT_LOADER_BITREV_EN
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = n[ADDR_WIDTH-1-i];
`endif
        return r;
    endfunction

    function automatic logic [LANES*WIDTH-1:0] expData(input int g);
        logic [LANES*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'(vals[g*LANES+k]);
        return r;
    endfunction

    function automatic logic [LANES*ADDR_WIDTH-1:0] expAddr(input int g);
        logic [LANES*ADDR_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[k*ADDR_WIDTH +: ADDR_WIDTH] = mapAddr(g*LANES+k);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one load; base<0 means random coefficients. startBeat/startInWrite inject ignored starts.
    task automatic applyStimulus(input int base, input int stallPct, input int startBeat,
                                 input bit startInWrite);
        int  idx;
        int  guard;
        bit  acc;
        bit  wroteStart;
        wrData.delete();
        wrAddr.delete();
        wrCyc.delete();
        doneCnt      = 0;
        readyInWrite = 0;
        for (int i = 0; i < DEPTH; i++)
            vals[i] = (base >= 0) ? (base + i) : int'($urandom_range(0, 4095));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        startCyc   = cyc;
        idx        = 0;
        guard      = 0;
        wroteStart = 1'b0;
        while (idx < DEPTH && guard < 4000) begin
            inData  = WIDTH'(vals[idx]);
            inValid = ($urandom_range(0, 99) >= stallPct);
            start   = (idx == startBeat);
            if (startInWrite && we && !wroteStart) begin
                start      = 1'b1;
                wroteStart = 1'b1;
            end
            #1;
            acc = inValid && inReady;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        inValid = 1'b0;
        start   = 1'b0;
        checkOutput("beatsAccepted", 192'(idx), 192'(DEPTH));
    endtask

    task automatic waitDone(input int tail);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (done) begin
                seen    = 1'b1;
                doneCyc = cyc;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("doneSeen", 192'(seen), 192'(1));
        repeat (tail) @(negedge clk);
        #1;
    endtask

    task automatic checkLoad(input string name, input bit checkTiming);
        int nw;
        nw = wrData.size();
        checkOutput({name, " writeCount"}, 192'(nw), 192'(GROUPS));
        checkOutput({name, " doneCount"}, 192'(doneCnt), 192'(1));
        for (int g = 0; g < nw && g < GROUPS; g++) begin
            checkOutput($sformatf("%s data g%0d", name, g), 192'(wrData[g]), 192'(expData(g)));
            checkOutput($sformatf("%s addr g%0d", name, g), 192'(wrAddr[g]), 192'(expAddr(g)));
        end
        if (checkTiming && nw == GROUPS) begin
            checkOutput({name, " firstWriteLatency"}, 192'(wrCyc[0] - startCyc), 192'(16));
            for (int g = 1; g < GROUPS; g++)
                checkOutput($sformatf("%s gap g%0d", name, g), 192'(wrCyc[g] - wrCyc[g-1]), 192'(17));
            checkOutput({name, " doneAfterLast"}, 192'(doneCyc - wrCyc[GROUPS-1]), 192'(1));
        end
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        cyc       = 0;
        doneCnt   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        inValid   = 1'b0;
        inData    = '0;

        // Power-on reset state
        repeat (3) @(negedge clk);
        checkOutput("rst busy", 192'(busy), 192'(0));
        checkOutput("rst we", 192'(we), 192'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle ready", 192'(inReady), 192'(0));
        checkOutput("idle done", 192'(done), 192'(0));

        // Natural unstalled load
        applyStimulus(0, 0, -1, 1'b0);
        waitDone(5);
        checkLoad("natural", 1'b1);
        if (wrData.size() == GROUPS) begin
`ifdef NTT_LOADER_BITREV_EN
            checkOutput("brev w0l1 addr", 192'(wrAddr[0][1*ADDR_WIDTH +: ADDR_WIDTH]), 192'(128));
            checkOutput("brev w0l1 data", 192'(wrData[0][1*WIDTH +: WIDTH]), 192'(1));
            checkOutput("brev w15l15 addr", 192'(wrAddr[15][15*ADDR_WIDTH +: ADDR_WIDTH]), 192'(255));
            checkOutput("brev w15l15 data", 192'(wrData[15][15*WIDTH +: WIDTH]), 192'(255));
            checkOutput("brev w1l0 addr", 192'(wrAddr[1][0 +: ADDR_WIDTH]), 192'(8));
            checkOutput("brev w1l0 data", 192'(wrData[1][0 +: WIDTH]), 192'(16));
`else
            checkOutput("nat w5l7 addr", 192'(wrAddr[5][7*ADDR_WIDTH +: ADDR_WIDTH]), 192'(87));
            checkOutput("nat w5l7 data", 192'(wrData[5][7*WIDTH +: WIDTH]), 192'(87));
`endif
        end
        checkOutput("post idle busy", 192'(busy), 192'(0));

        // Backpressure: ~30% invalid cycles
        applyStimulus(0, 30, -1, 1'b0);
        waitDone(5);
        checkLoad("stall", 1'b0);
        checkOutput("stall readyInWrite", 192'(readyInWrite), 192'(0));

        // Reset mid-FILL after 5 beats
        @(negedge clk);
        start = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            start   = 1'b0;
            inValid = 1'b1;
            inData  = WIDTH'($urandom_range(0, 4095));
        end
        @(negedge clk);
        inValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst ready", 192'(inReady), 192'(0));
        checkOutput("midrst busy", 192'(busy), 192'(0));
        checkOutput("midrst we", 192'(we), 192'(0));
        checkOutput("midrst done", 192'(done), 192'(0));
        checkOutput("midrst waddr", 192'(waddr), 192'(0));
        checkOutput("midrst din", 192'(din), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wrData.delete();
        repeat (20) @(negedge clk);
        #1;
        checkOutput("afterrst busy", 192'(busy), 192'(0));
        checkOutput("afterrst noWrite", 192'(wrData.size()), 192'(0));
        applyStimulus(-1, 0, -1, 1'b0);
        waitDone(5);
        checkLoad("afterrst", 1'b1);
        if (wrData.size() > 0)
            checkOutput("afterrst w0l0", 192'(wrData[0][0 +: WIDTH]), 192'(WIDTH'(vals[0])));

        // Ignored start pulses (beat 40 and first WRITE), then back-to-back load
        applyStimulus(0, 0, 40, 1'b1);
        waitDone(0);
        checkLoad("ignstart", 1'b1);
        applyStimulus(1000, 0, -1, 1'b0);
        waitDone(5);
        checkLoad("b2b", 1'b1);
        if (wrData.size() > 0) begin
            checkOutput("b2b w0l3 data", 192'(wrData[0][3*WIDTH +: WIDTH]), 192'(1003));
            checkOutput("b2b w0l3 addr", 192'(wrAddr[0][3*ADDR_WIDTH +: ADDR_WIDTH]), 192'(mapAddr(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ntt_coef_loader.md
Name: ntt_coef_loader

Overview:
- Upstream stage of the 16-port coefficient register file.
- Accepts a serial stream of WIDTH-bit coefficients on a valid/ready handshake and packs LANES consecutive coefficients into one wide word.
- Issues one LANES-wide write, with per-lane write addresses, per group.
- Loads a full DEPTH-entry polynomial per start command and signals completion.

Parameters:
- WIDTH, 12, coefficient width in bits.
- DEPTH, 256, coefficients per polynomial; must be a multiple of LANES.
- LANES, 16, write lanes per register-file write.
- ADDR_WIDTH, 8, register-file address width; DEPTH must equal 2**ADDR_WIDTH.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  begin a polynomial load; sampled in IDLE only.
- in_valid_i  input  1  in_data_i holds a valid coefficient.
- in_data_i  input  WIDTH  coefficient; natural index order 0..DEPTH-1.
- in_ready_o  output  1  loader accepts a beat this cycle.
- we_o  output  1  register-file write enable; one-cycle pulse per group.
- waddr_o  output  LANES*ADDR_WIDTH  lane k address at bits [(k+1)*ADDR_WIDTH-1 : k*ADDR_WIDTH].
- din_o  output  LANES*WIDTH  lane k data at bits [(k+1)*WIDTH-1 : k*WIDTH].
- busy_o  output  1  high in FILL and WRITE.
- done_o  output  1  one-cycle pulse after the last group write.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE; lane counter, group counter, pack buffer cleared.
  - All outputs 0: in_ready_o, we_o, busy_o, done_o, waddr_o, din_o.
- Reset mid-load aborts the load. No partial write is issued after reset release.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - in_ready_o=0.
  - start_i=1 -> FILL; lane_cnt=0, grp_cnt=0.
- FILL:
  - in_ready_o=1 (combinational from state).
  - A beat is accepted when in_valid_i && in_ready_o.
  - Accepted beat is stored in pack slot lane_cnt; lane_cnt increments.
  - in_valid_i=0 stalls with no state change.
  - When the beat accepted has lane_cnt==LANES-1 -> WRITE; lane_cnt wraps to 0.
- WRITE (exactly one cycle):
  - in_ready_o=0; we_o=1.
  - din_o = packed word (slot k on lane k).
  - Lane k address = natural index grp_cnt*LANES+k, mapped per Optional Feature.
  - grp_cnt increments. If grp_cnt was DEPTH/LANES-1 -> DONE, else -> FILL.
- DONE: done_o=1 for one cycle -> IDLE.
- Registered outputs:
  - we_o, waddr_o, din_o are registered.
  - din_o and waddr_o hold their last values when we_o=0. Consumers qualify them with we_o only.
- Latency:
  - 16th beat of a group accepted at edge t -> we_o=1 in cycle t+1.
  - Unstalled full load: 16 x (16 FILL + 1 WRITE) = 272 cycles from FILL entry to the last WRITE.
  - done_o asserts in the cycle after the last WRITE.
- start_i outside IDLE is ignored; no restart or abort.
- start_i in the DONE cycle is ignored; it is accepted only once back in IDLE.
- Data passes through unmodified; no modular reduction.
- All lane addresses within one write are distinct, so there are no write collisions downstream.

Optional Feature:
- Macro: NTT_LOADER_BITREV_EN.
- Defined: lane address = bit-reverse of the ADDR_WIDTH-bit natural index. Bit i of the address = bit ADDR_WIDTH-1-i of the index. Intended for input permutation ahead of decimation-in-time stages.
- Undefined: lane address = natural index.
- Data packing order, timing and handshake are identical in both builds.

Test Plan:
- Reset: assert rst_ni=0 mid-FILL (after 5 beats), release, then check:
  - outputs are all 0 and state is IDLE;
  - a fresh start_i followed by 256 beats gives the first we_o with lane0 data equal to the first beat after the new start.
- Natural load, no stalls: stream values 0..255.
  - 16 we_o pulses, each 17 cycles apart.
  - Write g carries lane k data = 16g+k and lane k address = 16g+k.
  - done_o pulses once, one cycle after the 16th write.
- Backpressure/stall: drop in_valid_i randomly about 30% of cycles.
  - Same 16 writes with identical data/address contents.
  - No beat lost or duplicated; in_ready_o=0 in every WRITE cycle.
- Ignored start: pulse start_i during FILL at beat 40 and during the WRITE cycle.
  - Load completes normally: exactly 16 writes, one done_o.
- Back-to-back loads: assert start_i in the cycle after done_o.
  - Second load with values 1000..1255 gives write 0 lane 3 data = 1003, address 3.
- NTT_LOADER_BITREV_EN build: stream 0..255.
  - Write 0 lane 1 has address 128 and data 1.
  - Write 15 lane 15 has address 255 and data 255.
  - Write 1 lane 0 has address 8 and data 16.
